// File: rtl/ila_readout_ctrl.sv
// ILA sample-buffer readout sequencer: walks the ring from the oldest sample into the serializer.
// Optional header bytes (sample count, little-endian) are emitted when READOUT_HEADER_EN is defined.
module ila_readout_ctrl #(
  parameter int addr_width  = 10,
  parameter int sample_cnt  = 2**addr_width,
  parameter int ram_latency = 1
) (
  input  logic                  i_clk_ILA,
  input  logic                  i_reset,
  input  logic                  i_start_readout,
  input  logic                  i_abort,
  input  logic [addr_width-1:0] i_start_addr,
  input  logic                  i_byte_done,
  input  logic                  i_sample_consumed,
  output logic [addr_width-1:0] o_ram_addr,
  output logic                  o_ram_rd_en,
  output logic                  o_read_active,
  output logic                  o_header_sel,
  output logic [7:0]            o_header_byte,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int              CW      = addr_width + 1;
  localparam logic [CW-1:0]   SC_LAST = CW'(sample_cnt);
  localparam logic [1:0]      PF_LAST = 2'(ram_latency);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREFETCH = 2'd1,
    S_HEADER   = 2'd2,
    S_STREAM   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [1:0]            pf_q, pf_d;
  logic                  rd_en_q, rd_en_d;
  logic                  active_q, active_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef READOUT_HEADER_EN
  localparam logic [15:0] HDR_VAL = 16'(sample_cnt);
  logic                  hdr_sel_q, hdr_sel_d;
  logic                  hdr_idx_q, hdr_idx_d;
  logic [7:0]            hdr_byte_q, hdr_byte_d;
`else
  logic                  unused_byte_done;
  assign unused_byte_done = i_byte_done;
`endif

  // Next-state and registered-output logic; abort in any busy state overrides everything.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    pf_d     = pf_q;
    rd_en_d  = rd_en_q;
    active_d = active_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef READOUT_HEADER_EN
    hdr_sel_d  = hdr_sel_q;
    hdr_idx_d  = hdr_idx_q;
    hdr_byte_d = hdr_byte_q;
`endif
    if ((state_q != S_IDLE) && i_abort) begin
      state_d  = S_IDLE;
      rd_en_d  = 1'b0;
      active_d = 1'b0;
      busy_d   = 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_sel_d  = 1'b0;
      hdr_byte_d = 8'h00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start_readout && !i_abort) begin
            addr_d  = i_start_addr;
            cnt_d   = {CW{1'b0}};
            pf_d    = 2'd0;
            rd_en_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_PREFETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PREFETCH: begin
          if (pf_q == PF_LAST) begin
            addr_d = addr_q + addr_width'(1);
`ifdef READOUT_HEADER_EN
            hdr_sel_d  = 1'b1;
            hdr_idx_d  = 1'b0;
            hdr_byte_d = HDR_VAL[7:0];
            state_d    = S_HEADER;
`else
            active_d = 1'b1;
            state_d  = S_STREAM;
`endif
          end else begin
            pf_d = pf_q + 2'd1;
          end
        end
`ifdef READOUT_HEADER_EN
        S_HEADER: begin
          if (i_byte_done) begin
            if (hdr_idx_q) begin
              hdr_sel_d  = 1'b0;
              hdr_byte_d = 8'h00;
              active_d   = 1'b1;
              state_d    = S_STREAM;
            end else begin
              hdr_idx_d  = 1'b1;
              hdr_byte_d = HDR_VAL[15:8];
            end
          end else begin
            state_d = S_HEADER;
          end
        end
`endif
        S_STREAM: begin
          if (i_sample_consumed) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == SC_LAST) begin
              done_d   = 1'b1;
              rd_en_d  = 1'b0;
              active_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end else begin
              addr_d = addr_q + addr_width'(1);
            end
          end else begin
            state_d = S_STREAM;
          end
        end
        default: begin
          state_d  = S_IDLE;
          rd_en_d  = 1'b0;
          active_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk_ILA or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      addr_q   <= {addr_width{1'b0}};
      cnt_q    <= {CW{1'b0}};
      pf_q     <= 2'd0;
      rd_en_q  <= 1'b0;
      active_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_sel_q  <= 1'b0;
      hdr_idx_q  <= 1'b0;
      hdr_byte_q <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      pf_q     <= pf_d;
      rd_en_q  <= rd_en_d;
      active_q <= active_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef READOUT_HEADER_EN
      hdr_sel_q  <= hdr_sel_d;
      hdr_idx_q  <= hdr_idx_d;
      hdr_byte_q <= hdr_byte_d;
`endif
    end
  end

  assign o_ram_addr    = addr_q;
  assign o_ram_rd_en   = rd_en_q;
  assign o_read_active = active_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
`ifdef READOUT_HEADER_EN
  assign o_header_sel  = hdr_sel_q;
  assign o_header_byte = hdr_byte_q;
`else
  assign o_header_sel  = 1'b0;
  assign o_header_byte = 8'h00;
`endif

endmodule

// File: tb/tb_ila_readout_ctrl.sv
// Scoreboard bench: three readout controllers (sample_cnt 16, 5, 1) share one stimulus stream;
// expected address/done events are queued per instance and popped by per-instance monitors.
module tb_ila_readout_ctrl;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, abort = 1'b0, byte_done = 1'b0, consumed = 1'b0;
  logic [AW-1:0] start_addr = '0;

  logic [AW-1:0] ram_addr [3];
  logic          rd_en [3], read_active [3], header_sel [3], busy [3], done [3];
  logic [7:0]    header_byte [3];

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_addr_q [3][$];
  logic          exp_done_q [3][$];

  always #5 clk = ~clk;

  function automatic int scv(input int g);
    return (g == 0) ? 16 : ((g == 1) ? 5 : 1);
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ila_readout_ctrl #(
      .addr_width (AW),
      .sample_cnt ((g == 0) ? 16 : ((g == 1) ? 5 : 1)),
      .ram_latency(1)
    ) u_dut (
      .i_clk_ILA        (clk),
      .i_reset          (rst),
      .i_start_readout  (start),
      .i_abort          (abort),
      .i_start_addr     (start_addr),
      .i_byte_done      (byte_done),
      .i_sample_consumed(consumed),
      .o_ram_addr       (ram_addr[g]),
      .o_ram_rd_en      (rd_en[g]),
      .o_read_active    (read_active[g]),
      .o_header_sel     (header_sel[g]),
      .o_header_byte    (header_byte[g]),
      .o_busy           (busy[g]),
      .o_done           (done[g])
    );

    logic          p_en;
    logic [AW-1:0] p_addr;

    // Monitor: every new read address and every done pulse must match the head of the queues.
    always @(negedge clk) begin
      if (rst) begin
        p_en = 1'b0;
      end else begin
        if (rd_en[g] && (!p_en || ram_addr[g] != p_addr)) begin
          if (exp_addr_q[g].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL addr_unexpected dut%0d: got %0h, expected no address", g, ram_addr[g]);
          end else begin
            chk("ram_addr", g, 32'(ram_addr[g]), 32'(exp_addr_q[g].pop_front()));
          end
        end
        if (done[g]) begin
          if (exp_done_q[g].size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL done_unexpected dut%0d: got 1, expected 0", g);
          end else begin
            chk("done_pulse", g, 32'(done[g]), 32'(exp_done_q[g].pop_front()));
          end
        end
        p_en   = rd_en[g];
        p_addr = ram_addr[g];
      end
    end
  end

  task automatic drive(input logic s, input logic a, input logic c, input logic b);
    @(posedge clk); #1;
    start = s; abort = a; consumed = c; byte_done = b;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0; consumed = 1'b0; byte_done = 1'b0;
  endtask

  task automatic levels(input string nm, input int g, input logic e_busy, input logic e_act, input logic e_en);
    chk({nm, "_busy"}, g, 32'(busy[g]), 32'(e_busy));
    chk({nm, "_read_active"}, g, 32'(read_active[g]), 32'(e_act));
    chk({nm, "_rd_en"}, g, 32'(rd_en[g]), 32'(e_en));
  endtask

  task automatic reset_zero(input string nm);
    for (int g = 0; g < 3; g++) begin
      levels(nm, g, 1'b0, 1'b0, 1'b0);
      chk({nm, "_addr"}, g, 32'(ram_addr[g]), 32'd0);
      chk({nm, "_done"}, g, 32'(done[g]), 32'd0);
      chk({nm, "_hdr_sel"}, g, 32'(header_sel[g]), 32'd0);
    end
  endtask

  // mode 0: normal then abort cleanup; 1: abort coincides with last consume; 2: async reset after consumes
  task automatic readout(input logic [AW-1:0] sa, input int ncons, input int mode);
    int eff, adv;
    logic [AW-1:0] a;
    logic [15:0] s16;
    eff = (mode == 1) ? ncons - 1 : ncons;
    for (int g = 0; g < 3; g++) begin
      adv = (eff < scv(g) - 1) ? eff : scv(g) - 1;
      a = sa;
      exp_addr_q[g].push_back(a);
      for (int k = 0; k <= adv; k++) begin
        a = a + 4'd1;
        exp_addr_q[g].push_back(a);
      end
      if (eff >= scv(g)) exp_done_q[g].push_back(1'b1);
    end
    start_addr = sa;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) levels("prefetch", g, 1'b1, 1'b0, 1'b1);
    start_addr = sa + 4'd8;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
`ifdef READOUT_HEADER_EN
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      s16 = 16'(scv(g));
      chk("hdr_sel", g, 32'(header_sel[g]), 32'd1);
      chk("hdr_byte0", g, 32'(header_byte[g]), 32'(s16[7:0]));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      s16 = 16'(scv(g));
      chk("hdr_byte1", g, 32'(header_byte[g]), 32'(s16[15:8]));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
`endif
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("stream_hdr_sel", g, 32'(header_sel[g]), 32'd0);
      chk("stream_hdr_byte", g, 32'(header_byte[g]), 32'd0);
    end
    for (int i = 0; i < ncons; i++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (i < scv(g)) chk("streaming", g, 32'(read_active[g]), 32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, (mode == 1 && i == ncons - 1), 1'b1, 1'b0);
      if (!(mode == 1 && i == ncons - 1)) repeat (4) @(posedge clk);
    end
    if (mode == 2) begin
      @(negedge clk); #2 rst = 1'b1;
      #1 reset_zero("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_zero("held_rst");
      #2 rst = 1'b0;
    end else begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (mode == 1 || eff >= scv(g)) levels("end", g, 1'b0, 1'b0, 1'b0);
      if (mode == 0) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        for (int g = 0; g < 3; g++) levels("cleanup", g, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_zero("reset");
    #2 rst = 1'b0;
    readout(4'd0, 16, 0);   // full ring from 0, wraps back to 0
    readout(4'd14, 5, 0);   // wrap 14,15,0,1,2
    readout(4'd9, 1, 0);    // single sample
    readout(4'd5, 4, 1);    // abort after 3 consumes
    readout(4'd2, 5, 1);    // abort together with final consume of the 5-sample instance
    start_addr = 4'd11;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) levels("start_abort_idle", g, 1'b0, 1'b0, 1'b0);
    readout(4'd3, 2, 2);    // reset mid-stream
    readout(4'd3, 5, 0);    // fresh readout after reset
    repeat (5) @(posedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("addr_queue_left", g, 32'(exp_addr_q[g].size()), 32'd0);
      chk("done_queue_left", g, 32'(exp_done_q[g].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
